// File: rtl/slave_mem_port.sv
// ---------------------------------------------------------------------------
// slave_mem_port
//   Memory-side port for the serial bus slave.
//
//   Each access follows the same sequence:
//   - A write strobe or a read strobe is accepted only while the port is idle.
//   - The access is performed on a local word array after a fixed latency.
//   - A one-cycle module_dv pulse then releases the slave from its wait.
//
//   A write that arrives in the same cycle as a read wins; the read is dropped.
//   Strobes that arrive while the port is busy, including the DONE cycle, are
//   ignored. They are not queued.
//
//   If the ID field does not match SELF_ID, nothing happens to the array and
//   data_out is left alone. The access still takes the normal latency and
//   completes with addr_err set, so the slave never deadlocks.
//
//   Optional feature macro: SLAVE_MEM_PARITY_EN
//   When it is defined:
//   - Each stored word carries an even-parity bit.
//   - A read whose parity fails raises parity_err alongside module_dv.
//
// Ports
//   clk, rstn     clock, asynchronous active-low reset
//   wr_en, rd_en  one-cycle write / read strobes
//   addr          full bus address; the top 3 bits are the slave ID
//   data_in       write data
//   data_out      read data; it holds until the next successful read
//   module_dv     one-cycle completion pulse
//   mem_busy      high while an access is in flight, through the module_dv cycle
//   addr_err      set with module_dv when the ID does not match
//   parity_err    set with module_dv on a read parity failure (macro only)
// ---------------------------------------------------------------------------
module slave_mem_port #(
    parameter int         ADDRESS_WIDTH = 15,
    parameter int         DATA_WIDTH    = 8,
    parameter int         MEM_DEPTH_LOG = 12,
    parameter int         WR_LATENCY    = 2,
    parameter int         RD_LATENCY    = 4,
    parameter logic [2:0] SELF_ID       = 3'b0
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     wr_en,
    input  logic                     rd_en,
    input  logic [ADDRESS_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0]    data_in,
    output logic [DATA_WIDTH-1:0]    data_out,
    output logic                     module_dv,
    output logic                     mem_busy,
`ifdef SLAVE_MEM_PARITY_EN
    output logic                     addr_err,
    output logic                     parity_err
`else
    output logic                     addr_err
`endif
);

`ifdef SLAVE_MEM_PARITY_EN
    localparam int MW = DATA_WIDTH + 1;
`else
    localparam int MW = DATA_WIDTH;
`endif

    localparam logic [3:0] WR_LOAD = 4'(WR_LATENCY - 1);
    localparam logic [3:0] RD_LOAD = 4'(RD_LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WR_WAIT, RD_WAIT, DONE} state_t;

    typedef struct packed {
        logic [MEM_DEPTH_LOG-1:0] addr;
        logic [DATA_WIDTH-1:0]    data;
        logic                     id_ok;
    } req_t;

    state_t state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    req_t req;
    logic cap_wr, cap_rd, access;
    logic mem_we, rd_ok;
    logic [MW-1:0] mem [2**MEM_DEPTH_LOG];
    logic [MW-1:0] wr_word, rd_word;
    logic id_match;

    // Address bits between the array index and the ID field alias and are
    // intentionally dropped.
    logic unused_addr;
    assign unused_addr = ^addr;

    assign id_match = (addr[ADDRESS_WIDTH-1 -: 3] == SELF_ID);

    // Next-state logic. The counter reaching zero in a wait state is the
    // cycle in which the array access happens.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        cap_wr    = 1'b0;
        cap_rd    = 1'b0;
        access    = 1'b0;
        case (state)
            IDLE: begin
                if (wr_en) begin
                    state_nxt = WR_WAIT;
                    cnt_nxt   = WR_LOAD;
                    cap_wr    = 1'b1;
                end else if (rd_en) begin
                    state_nxt = RD_WAIT;
                    cnt_nxt   = RD_LOAD;
                    cap_rd    = 1'b1;
                end
            end
            WR_WAIT, RD_WAIT: begin
                if (cnt == 4'd0) begin
                    state_nxt = DONE;
                    access    = 1'b1;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign mem_we = access && (state == WR_WAIT) && req.id_ok;
    assign rd_ok  = access && (state == RD_WAIT) && req.id_ok;

`ifdef SLAVE_MEM_PARITY_EN
    assign wr_word = {^req.data, req.data};
`else
    assign wr_word = req.data;
`endif
    assign rd_word = mem[req.addr];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            req        <= '0;
            data_out   <= '0;
            module_dv  <= 1'b0;
            mem_busy   <= 1'b0;
            addr_err   <= 1'b0;
`ifdef SLAVE_MEM_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            module_dv <= access;
            addr_err  <= access && !req.id_ok;
            // This makes busy rise one edge after the strobe is taken. It
            // stays high through the DONE cycle.
            mem_busy  <= (state == WR_WAIT) || (state == RD_WAIT);
            if (cap_wr || cap_rd) begin
                req.addr  <= addr[MEM_DEPTH_LOG-1:0];
                req.id_ok <= id_match;
            end
            if (cap_wr)
                req.data <= data_in;
            if (rd_ok)
                data_out <= rd_word[DATA_WIDTH-1:0];
`ifdef SLAVE_MEM_PARITY_EN
            // Even parity: the XOR over the data and the stored bit must be zero.
            parity_err <= rd_ok && (^rd_word);
`endif
        end
    end

    // The array has no reset. Its contents survive rstn.
    always_ff @(posedge clk) begin
        if (mem_we)
            mem[req.addr] <= wr_word;
    end

endmodule

// File: tb/tb_slave_mem_port.sv
module tb_slave_mem_port;
    localparam int AW  = 15;
    localparam int DW  = 8;
    localparam int MDL = 12;
    localparam int WRL = 2;
    localparam int RDL = 4;
    localparam logic [2:0] SID = 3'b0;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic wr_en = 1'b0, rd_en = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] data_in = '0;
    logic [DW-1:0] data_out;
    logic module_dv, mem_busy, addr_err;
`ifdef SLAVE_MEM_PARITY_EN
    logic parity_err;
`endif

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b1;

    always #5 clk = ~clk;

    slave_mem_port #(
        .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH_LOG(MDL),
        .WR_LATENCY(WRL), .RD_LATENCY(RDL), .SELF_ID(SID)
    ) dut (
        .clk(clk), .rstn(rstn), .wr_en(wr_en), .rd_en(rd_en),
        .addr(addr), .data_in(data_in), .data_out(data_out),
        .module_dv(module_dv), .mem_busy(mem_busy),
`ifdef SLAVE_MEM_PARITY_EN
        .addr_err(addr_err), .parity_err(parity_err)
`else
        .addr_err(addr_err)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // One access in flight at most, described by its accept edge and the
    // edge at which it completes. The port is free again one edge after
    // completion, and that edge itself ignores strobes.
    logic [DW-1:0] mmem [2**MDL];
    initial for (int i = 0; i < 2**MDL; i++) mmem[i] = '0;

    int cyc = 0;
    bit act = 1'b0;
    bit t_wr;
    logic [AW-1:0] t_addr;
    logic [DW-1:0] t_data;
    int t_start, t_done;
    logic e_dv = 0, e_busy = 0, e_aerr = 0;
    logic [DW-1:0] e_dout = '0;

    always @(posedge clk) begin
        cyc++;
        if (!rstn) begin
            act = 0; e_dv = 0; e_busy = 0; e_aerr = 0; e_dout = '0;
        end else begin
            e_dv = 0; e_aerr = 0;
            if (!act) begin
                if (wr_en || rd_en) begin
                    act = 1; t_wr = wr_en; t_addr = addr; t_data = data_in;
                    t_start = cyc; t_done = cyc + (wr_en ? WRL : RDL);
                end
            end else if (cyc == t_done) begin
                e_dv = 1;
                if (t_addr[AW-1:AW-3] != SID) e_aerr = 1;
                else if (t_wr) mmem[t_addr[MDL-1:0]] = t_data;
                else e_dout = mmem[t_addr[MDL-1:0]];
            end else if (cyc == t_done + 1) begin
                act = 0;
            end
            e_busy = act && (cyc > t_start) && (cyc <= t_done);
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check("module_dv", 32'(module_dv), 32'(e_dv));
            check("mem_busy",  32'(mem_busy),  32'(e_busy));
            check("addr_err",  32'(addr_err),  32'(e_aerr));
            check("data_out",  32'(data_out),  32'(e_dout));
`ifdef SLAVE_MEM_PARITY_EN
            check("parity_err", 32'(parity_err), 32'd0);
`endif
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic strobe(input bit w, input bit r, input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk); #2;
        wr_en = w; rd_en = r; addr = a; data_in = d;
        @(negedge clk); #2;
        wr_en = 0; rd_en = 0;
    endtask

    // Returns the number of edges from the strobe edge to module_dv.
    task automatic wait_dv(input string name, output int lat);
        lat = 0;
        while (!module_dv && lat < 40) begin
            @(negedge clk); #2;
            lat++;
        end
        if (!module_dv) check({name, "_timeout"}, 32'd1, 32'd0);
    endtask

    task automatic count_dv(input int n, output int c);
        c = 0;
        repeat (n) begin
            @(negedge clk); #2;
            if (module_dv) c++;
        end
    endtask

    initial begin
        int lat, c, r;
        // reset state
        repeat (2) @(negedge clk);
        #2;
        check("rst_dv", 32'(module_dv), 32'd0);
        check("rst_busy", 32'(mem_busy), 32'd0);
        check("rst_aerr", 32'(addr_err), 32'd0);
        check("rst_dout", 32'(data_out), 32'd0);
        rstn = 1'b1;

        // basic write / read
        strobe(1, 0, 15'h0012, 8'hA5);
        wait_dv("wr1", lat);
        check("wr1_lat", 32'(lat), 32'd2);
        check("wr1_aerr", 32'(addr_err), 32'd0);
        check("wr1_busy", 32'(mem_busy), 32'd1);
        @(negedge clk); #2;
        check("idle_busy", 32'(mem_busy), 32'd0);
        strobe(0, 1, 15'h0012, 8'h00);
        wait_dv("rd1", lat);
        check("rd1_lat", 32'(lat), 32'd4);
        check("rd1_data", 32'(data_out), 32'hA5);

        // ID mismatch leaves the array untouched
        strobe(1, 0, 15'h4012, 8'h3C);
        wait_dv("idw", lat);
        check("idw_lat", 32'(lat), 32'd2);
        check("idw_aerr", 32'(addr_err), 32'd1);
        strobe(0, 1, 15'h0012, 8'h00);
        wait_dv("idr", lat);
        check("idr_data", 32'(data_out), 32'hA5);
        check("idr_aerr", 32'(addr_err), 32'd0);

        // simultaneous strobes: write wins
        strobe(1, 1, 15'h0033, 8'h77);
        wait_dv("sim", lat);
        check("sim_lat", 32'(lat), 32'd2);
        check("sim_hold", 32'(data_out), 32'hA5);
        count_dv(8, c);
        check("sim_extra_dv", 32'(c), 32'd0);
        strobe(0, 1, 15'h0033, 8'h00);
        wait_dv("sim_rd", lat);
        check("sim_rd_data", 32'(data_out), 32'h77);

        // read strobe during WR_WAIT is dropped
        strobe(1, 0, 15'h0040, 8'h5A);
        rd_en = 1; addr = 15'h0040;
        @(negedge clk); #2;
        rd_en = 0;
        count_dv(12, c);
        check("busy_rd_dv", 32'(c), 32'd1);

        // reset mid-write: no completion, no commit
        strobe(1, 0, 15'h0005, 8'hFF);
        rstn = 0;
        #1;
        check("mid_rst_busy", 32'(mem_busy), 32'd0);
        @(negedge clk); #2;
        check("mid_rst_dout", 32'(data_out), 32'd0);
        rstn = 1;
        count_dv(8, c);
        check("mid_rst_dv", 32'(c), 32'd0);
        strobe(0, 1, 15'h0005, 8'h00);
        wait_dv("mid_rst_rd", lat);
        check("mid_rst_rdata", 32'(data_out), 32'h00);

        // top of array, unwritten word, hold through a write
        strobe(1, 0, 15'h0FFF, 8'h11);
        wait_dv("top_wr", lat);
        strobe(0, 1, 15'h0FFF, 8'h00);
        wait_dv("top_rd", lat);
        check("top_rdata", 32'(data_out), 32'h11);
        strobe(0, 1, 15'h0100, 8'h00);
        wait_dv("unw_rd", lat);
        check("unw_rdata", 32'(data_out), 32'h00);
        strobe(1, 0, 15'h0101, 8'h22);
        wait_dv("hold_wr", lat);
        check("hold_dout", 32'(data_out), 32'h00);

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk); #2;
            r = $urandom_range(0, 99);
            wr_en = (r < 15);
            rd_en = (r >= 10 && r < 28);
            addr = {(($urandom_range(0, 9) == 0) ? 3'($urandom_range(1, 7)) : 3'd0),
                    12'($urandom_range(0, 15))};
            data_in = 8'($urandom);
            rstn = ($urandom_range(0, 199) != 0);
        end
        @(negedge clk); #2;
        wr_en = 0; rd_en = 0; rstn = 1;
        repeat (10) @(negedge clk);

`ifdef SLAVE_MEM_PARITY_EN
        chk_on = 0;
        strobe(1, 0, 15'h0012, 8'hA5);
        wait_dv("par_wr", lat);
        @(negedge clk);
        dut.mem[18][0] = ~dut.mem[18][0];
        strobe(0, 1, 15'h0012, 8'h00);
        wait_dv("par_rd", lat);
        check("par_err", 32'(parity_err), 32'd1);
        check("par_data", 32'(data_out), 32'hA4);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
